// File: rtl/calc_pkg.sv
// Types and key-code constants shared by the keypad front end and the calculator core.
package calc_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        RELEASE
    } scan_state_t;

    // Key codes follow the row*4 + col position on the matrix.
    localparam logic [KEY_W-1:0] KEY_0 = 4'h0;
    localparam logic [KEY_W-1:0] KEY_1 = 4'h1;
    localparam logic [KEY_W-1:0] KEY_2 = 4'h2;
    localparam logic [KEY_W-1:0] KEY_3 = 4'h3;
    localparam logic [KEY_W-1:0] KEY_4 = 4'h4;
    localparam logic [KEY_W-1:0] KEY_5 = 4'h5;
    localparam logic [KEY_W-1:0] KEY_6 = 4'h6;
    localparam logic [KEY_W-1:0] KEY_7 = 4'h7;
    localparam logic [KEY_W-1:0] KEY_8 = 4'h8;
    localparam logic [KEY_W-1:0] KEY_9 = 4'h9;
    localparam logic [KEY_W-1:0] KEY_A = 4'hA;
    localparam logic [KEY_W-1:0] KEY_B = 4'hB;
    localparam logic [KEY_W-1:0] KEY_C = 4'hC;
    localparam logic [KEY_W-1:0] KEY_D = 4'hD;
    localparam logic [KEY_W-1:0] KEY_E = 4'hE;
    localparam logic [KEY_W-1:0] KEY_F = 4'hF;

    function automatic logic [KEY_W-1:0] key_of(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad rows; resets to the idle (all-high) level.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, debounced press/release FSM and a one-entry valid/ready output.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             overrun
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0] row_sync;

    sync_2ff #(.W(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_sync)
    );

    scan_state_t      state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       cand_row_q, cand_row_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] rel_q, rel_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             overrun_q, overrun_d;

    logic       sample;
    logic       row_single;
    logic       row_none;
    logic [1:0] sample_row;
    logic       advance;
    logic       emit;
    logic       accept;
    logic [CNT_W-1:0] match_inc;
    logic [CNT_W-1:0] rel_inc;

    // Row classification: anything other than exactly one low row is treated as no key.
    always_comb begin
        row_single = 1'b1;
        sample_row = 2'd0;
        case (~row_sync)
            4'b0001: sample_row = 2'd0;
            4'b0010: sample_row = 2'd1;
            4'b0100: sample_row = 2'd2;
            4'b1000: sample_row = 2'd3;
            default: row_single = 1'b0;
        endcase
        row_none = (row_sync == 4'b1111);
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        sample     = (slot_q == SLOT_LAST);
        slot_d     = sample ? '0 : slot_q + SLOT_W'(1);
        state_d    = state_q;
        col_d      = col_q;
        cand_row_d = cand_row_q;
        match_d    = match_q;
        rel_d      = rel_q;
        match_inc  = match_q + CNT_W'(1);
        rel_inc    = rel_q + CNT_W'(1);
        advance    = 1'b0;
        emit       = 1'b0;

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (row_single) begin
                        cand_row_d = sample_row;
                        match_d    = CNT_W'(1);
                        if (CNT_DONE == CNT_W'(1)) begin
                            emit    = 1'b1;
                            rel_d   = '0;
                            state_d = RELEASE;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_single && sample_row == cand_row_q) begin
                        match_d = match_inc;
                        if (match_inc == CNT_DONE) begin
                            emit    = 1'b1;
                            rel_d   = '0;
                            state_d = RELEASE;
                        end
                    end else begin
                        match_d = '0;
                        advance = 1'b1;
                        state_d = SCAN;
                    end
                end
                RELEASE: begin
                    if (!row_none) begin
                        rel_d = '0;
                    end else if (rel_inc == CNT_DONE) begin
                        rel_d   = '0;
                        advance = 1'b1;
                        state_d = SCAN;
                    end else begin
                        rel_d = rel_inc;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        if (advance) begin
            col_d = col_q + 2'd1;
        end
        col_out_d = ~(4'b0001 << col_d);
    end

    // One-entry output buffer; a key arriving on the accept cycle replaces the one leaving.
    always_comb begin
        accept      = key_valid_q && key_ready;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = 1'b0;
        if (emit) begin
            if (!key_valid_q || key_ready) begin
                key_code_d  = key_of(cand_row_d, col_q);
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            slot_q      <= '0;
            col_q       <= 2'd0;
            cand_row_q  <= 2'd0;
            match_q     <= '0;
            rel_q       <= '0;
            col_out_q   <= 4'b1110;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            col_q       <= col_d;
            cand_row_q  <= cand_row_d;
            match_q     <= match_d;
            rel_q       <= rel_d;
            col_out_q   <= col_out_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 and a switch-matrix keypad model.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overrun;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven; force_* overrides the rows.
    logic [15:0] press_mask;
    logic        force_en;
    logic [3:0]  force_rows;
    logic [3:0]  kp_rows;

    always_comb begin
        kp_rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_mask[r*4+c] && !col_out[c]) kp_rows[r] = 1'b0;
        row_in = force_en ? force_rows : kp_rows;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshake monitor, sampled 1 ns after the falling edge.
    int         vrise_cnt = 0;
    int         ovr_cnt   = 0;
    int         acc_cnt   = 0;
    int         proto_err = 0;
    logic [3:0] last_acc  = 4'h0;
    logic       prev_valid = 1'b0;
    logic       prev_acc   = 1'b0;
    logic [3:0] prev_code  = 4'h0;

    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (key_valid && !prev_valid) vrise_cnt++;
            if (overrun) ovr_cnt++;
            if (key_valid && key_ready) begin
                acc_cnt++;
                last_acc = key_code;
            end
            if (prev_valid && key_valid && !prev_acc && key_code != prev_code) proto_err++;
            if (prev_valid && !key_valid && !prev_acc) proto_err++;
            if (overrun && key_code != prev_code) proto_err++;
        end
        prev_valid = key_valid;
        prev_acc   = key_valid && key_ready;
        prev_code  = key_code;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col_is(input string tag, input logic [3:0] target);
        for (int i = 0; i < 200 && col_out != target; i++) @(negedge clk);
        check(tag, col_out, target);
    endtask

    task automatic wait_col_change(input string tag, input logic [3:0] target);
        logic [3:0] old;
        old = col_out;
        for (int i = 0; i < 200 && col_out == old; i++) @(negedge clk);
        check(tag, col_out, target);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200 && !key_valid; i++) @(negedge clk);
        check(tag, key_valid, 1);
    endtask

    task automatic wait_overrun(input string tag, input int base);
        for (int i = 0; i < 200 && ovr_cnt == base; i++) @(negedge clk);
        check(tag, ovr_cnt, base + 1);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] col_seq [4];
    int v0, o0, a0;

    initial begin
        rst        = 1'b1;
        key_ready  = 1'b1;
        press_mask = 16'h0;
        force_en   = 1'b0;
        force_rows = 4'b1111;
        col_seq    = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        tick(2);
        rst = 1'b0;

        // Reset mid-slot acts immediately, then columns rotate every 4 cycles.
        tick(6);
        check("pre_reset_col", col_out, 4'b1101);
        #2 rst = 1'b1;
        #1;
        check("rst_col", col_out, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_code", key_code, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        check("scan_col0", col_out, 4'b1110);
        for (int k = 0; k < 4; k++) begin
            tick(k == 0 ? 3 : 4);
            check("scan_rotate", col_out, col_seq[k]);
        end

        // Clean press of key 9 (row 2, col 1) with the consumer always ready.
        press_mask = 16'h0200;
        wait_col_is("press9_col", 4'b1101);
        v0 = vrise_cnt;
        tick(11);
        check("press9_not_yet", key_valid, 0);
        tick(1);
        check("press9_valid", key_valid, 1);
        check("press9_code", key_code, 4'h9);
        tick(1);
        check("press9_pulse", key_valid, 0);
        check("press9_frozen", col_out, 4'b1101);
        check("press9_one_rise", vrise_cnt, v0 + 1);
        press_mask = 16'h0;
        wait_col_change("press9_resume", 4'b1011);

        // Bounce: row 0 low for one slot only, on column 2.
        force_en   = 1'b1;
        force_rows = 4'b1110;
        v0 = vrise_cnt;
        tick(4);
        force_rows = 4'b1111;
        wait_col_change("bounce_resume", 4'b0111);
        check("bounce_no_key", vrise_cnt, v0);

        // Row 0 low for three slots on column 3 is accepted as key 3.
        force_rows = 4'b1110;
        tick(12);
        check("bounce3_valid", key_valid, 1);
        check("bounce3_code", key_code, 4'h3);
        force_rows = 4'b1111;
        wait_col_change("bounce3_resume", 4'b1110);
        force_en = 1'b0;

        // Back-pressure: key 5 held, key 10 dropped with one overrun pulse.
        key_ready  = 1'b0;
        o0 = ovr_cnt;
        press_mask = 16'h0020;
        wait_valid("bp_valid5");
        check("bp_code5", key_code, 4'h5);
        press_mask = 16'h0400;
        wait_overrun("bp_overrun", o0);
        tick(2);
        check("bp_hold_code", key_code, 4'h5);
        check("bp_hold_valid", key_valid, 1);
        press_mask = 16'h0;
        tick(20);
        check("bp_single_overrun", ovr_cnt, o0 + 1);
        key_ready = 1'b1;
        tick(1);
        check("bp_consumed", key_valid, 0);
        check("bp_consumed_code", last_acc, 4'h5);
        key_ready = 1'b0;

        // Same-cycle emit and accept: key 3 pending, key 4 loads on its accept cycle.
        press_mask = 16'h0008;
        wait_valid("same_valid3");
        check("same_code3", key_code, 4'h3);
        press_mask = 16'h0010;
        o0 = ovr_cnt;
        a0 = acc_cnt;
        wait_col_is("same_col0", 4'b1110);
        tick(11);
        key_ready = 1'b1;
        tick(1);
        check("same_valid_held", key_valid, 1);
        check("same_code4", key_code, 4'h4);
        check("same_no_overrun", ovr_cnt, o0);
        check("same_accepted3", last_acc, 4'h3);
        tick(1);
        check("same_drain", key_valid, 0);
        check("same_accepted4", last_acc, 4'h4);
        check("same_acc_count", acc_cnt, a0 + 2);
        key_ready  = 1'b0;
        press_mask = 16'h0;
        wait_col_change("same_resume", 4'b1101);

        // Rows 1 and 3 low together never produce a key and scanning keeps moving.
        force_en   = 1'b1;
        force_rows = 4'b0101;
        v0 = vrise_cnt;
        tick(40);
        check("multi_no_key", vrise_cnt, v0);
        check("multi_scanning", col_out, 4'b0111);

        // Pending key 3, then reset during a fresh debounce discards everything.
        force_rows = 4'b1110;
        tick(12);
        check("pend_valid", key_valid, 1);
        check("pend_code", key_code, 4'h3);
        force_rows = 4'b1111;
        wait_col_change("pend_resume", 4'b1110);
        force_rows = 4'b1110;
        tick(6);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_col", col_out, 4'b1110);
        check("mid_rst_overrun", overrun, 0);
        force_rows = 4'b1111;
        tick(2);
        rst = 1'b0;
        v0 = vrise_cnt;
        tick(40);
        check("post_rst_no_key", vrise_cnt, v0);
        check("post_rst_valid", key_valid, 0);
        force_en = 1'b0;

        check("handshake_protocol", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
